// File: rtl/ru_arb_pkg.sv
// Package: ru_arb_pkg
// Purpose: shared types and constants for the remote-update access arbiter.
//   state_t     - arbiter FSM states
//   OP_GET/SET  - per-requester operation encoding
//   IMG_INVALID - image code rejected by a set and returned by a failed get
package ru_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_GET,
    GUARD,
    LOCKED
  } state_t;

  localparam logic OP_GET = 1'b0;
  localparam logic OP_SET = 1'b1;

  localparam logic [1:0] IMG_INVALID = 2'b00;

  // A set with the invalid code is answered with an error instead of reconfiguring.
  function automatic logic img_is_valid(input logic [1:0] img);
    return img != IMG_INVALID;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Module: rr_pick
// Purpose: combinational cyclic first-one picker. Starting at i_ptr and wrapping
//   around, returns the first set bit of i_req.
// Ports:
//   i_req   [N-1:0]          request vector
//   i_ptr   [$clog2(N)-1:0]  search start position (must be < N)
//   o_valid                  any request present
//   o_grant [N-1:0]          one-hot grant (all zero when o_valid = 0)
//   o_idx   [$clog2(N)-1:0]  index of the granted bit
module rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_valid,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int unsigned IW = $clog2(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic           w_found;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  // Rotating a doubled copy puts bit i_ptr at position 0, so the first set bit of
  // w_rot is the offset from i_ptr to the winner.
  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IW'(k);
      end
    end
    // ptr + off < 2N, so a single conditional subtract gives the modulo.
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (IW + 1)'(N)) begin
      w_sum = w_sum - (IW + 1)'(N);
    end
    o_valid = w_found;
    o_idx   = w_sum[IW-1:0];
    o_grant = '0;
    if (w_found) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ru_access_arbiter.sv
// Module: ru_access_arbiter
// Purpose: shares one remote-update image-control engine between NUM_REQ
//   requesters. Requests are granted round-robin; each engine operation is issued,
//   awaited (get only, with timeout) and followed by a guard gap. A valid set
//   reconfigures the FPGA, so the arbiter locks until reset.
// Ports:
//   i_clk, i_reset            clock; synchronous active-high reset
//   i_req_valid [NUM_REQ]     request pending, held until o_req_ready
//   i_req_op    [NUM_REQ]     0 = get image, 1 = set image
//   i_req_img   [2*NUM_REQ]   target image per requester (slice i = [2i+1:2i])
//   o_req_ready [NUM_REQ]     one-hot accept pulse
//   o_rsp_valid [NUM_REQ]     one-hot completion pulse
//   o_rsp_img   [2]           image read by a get (00 on error)
//   o_rsp_err                 timeout or invalid set code
//   o_busy                    not idle
//   o_locked                  set issued; cleared only by reset
//   o_start_setimg/getimg     engine start pulses
//   o_setimg    [2]           image code to the engine
//   i_getimg    [2]           engine result, sampled with i_done_getimg
//   i_done_getimg             engine completion pulse
module ru_access_arbiter
  import ru_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned GUARD_CYC   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ-1:0]     i_req_op,
  input  logic [2*NUM_REQ-1:0]   i_req_img,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [1:0]             o_rsp_img,
  output logic                   o_rsp_err,
  output logic                   o_busy,
  output logic                   o_locked,
  output logic                   o_start_setimg,
  output logic                   o_start_getimg,
  output logic [1:0]             o_setimg,
  input  logic [1:0]             i_getimg,
  input  logic                   i_done_getimg
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_REQ - 1);

  state_t               r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_idx;
  logic                 r_op;
  logic [1:0]           r_img;
  logic [TW-1:0]        r_timer;
  logic [GW-1:0]        r_guard;

  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [1:0]           r_rsp_img;
  logic                 r_rsp_err;
  logic                 r_busy;
  logic                 r_locked;
  logic                 r_start_setimg;
  logic                 r_start_getimg;
  logic [1:0]           r_setimg;

  logic                 w_pick_valid;
  logic [NUM_REQ-1:0]   w_pick_grant;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_pick_op;
  logic [1:0]           w_pick_img;
  logic [NUM_REQ-1:0]   w_idx_oh;
  logic [IW-1:0]        w_ptr_next;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_pick_op  = i_req_op[w_pick_idx];
    w_pick_img = i_req_img[{w_pick_idx, 1'b0} +: 2];
    w_idx_oh   = NUM_REQ'(1) << r_idx;
    w_ptr_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
  end

  // Single-process FSM. All outputs are registered: they are decided on the edge
  // that enters the state in which they are visible, so req_ready and the start
  // pulse appear during ISSUE and responses appear one cycle after their cause.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_idx          <= '0;
      r_op           <= OP_GET;
      r_img          <= IMG_INVALID;
      r_timer        <= '0;
      r_guard        <= '0;
      r_req_ready    <= '0;
      r_rsp_valid    <= '0;
      r_rsp_img      <= IMG_INVALID;
      r_rsp_err      <= 1'b0;
      r_busy         <= 1'b0;
      r_locked       <= 1'b0;
      r_start_setimg <= 1'b0;
      r_start_getimg <= 1'b0;
      r_setimg       <= IMG_INVALID;
    end else begin
      // Pulsed outputs default low; response payload is zero outside the pulse.
      r_req_ready    <= '0;
      r_rsp_valid    <= '0;
      r_rsp_img      <= IMG_INVALID;
      r_rsp_err      <= 1'b0;
      r_start_setimg <= 1'b0;
      r_start_getimg <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_idx       <= w_pick_idx;
            r_op        <= w_pick_op;
            r_img       <= w_pick_img;
            r_req_ready <= w_pick_grant;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
            if (w_pick_op == OP_GET) begin
              r_start_getimg <= 1'b1;
            end else if (img_is_valid(w_pick_img)) begin
              r_start_setimg <= 1'b1;
              r_setimg       <= w_pick_img;
            end
          end
        end

        ISSUE: begin
          if (r_op == OP_GET) begin
            r_timer <= '0;
            r_state <= WAIT_GET;
          end else if (img_is_valid(r_img)) begin
            r_locked <= 1'b1;
            r_state  <= LOCKED;
          end else begin
            r_rsp_valid <= w_idx_oh;
            r_rsp_err   <= 1'b1;
            r_guard     <= '0;
            r_state     <= GUARD;
          end
        end

        WAIT_GET: begin
          // Completion is checked first so it wins over a simultaneous timeout.
          if (i_done_getimg) begin
            r_rsp_valid <= w_idx_oh;
            r_rsp_img   <= i_getimg;
            r_guard     <= '0;
            r_state     <= GUARD;
          end else if (r_timer == TIMER_LAST) begin
            r_rsp_valid <= w_idx_oh;
            r_rsp_err   <= 1'b1;
            r_guard     <= '0;
            r_state     <= GUARD;
          end else if (r_timer != TIMER_MAX) begin
            r_timer <= r_timer + 1'b1;
          end
        end

        GUARD: begin
          if (r_guard == GUARD_LAST) begin
            r_ptr   <= w_ptr_next;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end

        LOCKED: begin
          // Terminal until reset: the engine is reconfiguring the device.
          r_busy   <= 1'b1;
          r_locked <= 1'b1;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_img      = r_rsp_img;
  assign o_rsp_err      = r_rsp_err;
  assign o_busy         = r_busy;
  assign o_locked       = r_locked;
  assign o_start_setimg = r_start_setimg;
  assign o_start_getimg = r_start_getimg;
  assign o_setimg       = r_setimg;

endmodule

// File: tb/tb_ru_access_arbiter.sv
// Testbench: tb_ru_access_arbiter
// Purpose: directed self-checking bench for ru_access_arbiter with a behavioural
//   image-control engine (programmable done delay and getimg value).
module tb_ru_access_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned TO_CYC  = 64;
  localparam int unsigned G_CYC   = 4;

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic [NUM_REQ-1:0]   i_req_valid = '0;
  logic [NUM_REQ-1:0]   i_req_op = '0;
  logic [2*NUM_REQ-1:0] i_req_img = '0;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [NUM_REQ-1:0]   o_rsp_valid;
  logic [1:0]           o_rsp_img;
  logic                 o_rsp_err;
  logic                 o_busy;
  logic                 o_locked;
  logic                 o_start_setimg;
  logic                 o_start_getimg;
  logic [1:0]           o_setimg;
  logic [1:0]           i_getimg;
  logic                 i_done_getimg;

  // Engine model controls.
  int          eng_delay = 0;   // 0 = never answer
  logic [1:0]  eng_img = 2'b00;
  logic        stray_done = 1'b0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;

  // Monitor state (written only by the monitor process).
  int          cyc = 0;
  int          n_ready = 0, n_rsp = 0, n_sget = 0, n_sset = 0;
  int          issue_cyc = 0, rsp_cyc = 0;
  logic [1:0]  last_rsp_vec = '0, last_rsp_img = '0, last_sset_img = '0;
  logic        last_rsp_err = 1'b0;
  logic [1:0]  grants[$];
  int          sget_cycs[$];

  int n_tests = 0;
  int n_fail  = 0;

  assign i_getimg      = eng_img;
  assign i_done_getimg = m_done | stray_done;

  ru_access_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TO_CYC),
    .GUARD_CYC   (G_CYC)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .i_req_op       (i_req_op),
    .i_req_img      (i_req_img),
    .o_req_ready    (o_req_ready),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_img      (o_rsp_img),
    .o_rsp_err      (o_rsp_err),
    .o_busy         (o_busy),
    .o_locked       (o_locked),
    .o_start_setimg (o_start_setimg),
    .o_start_getimg (o_start_getimg),
    .o_setimg       (o_setimg),
    .i_getimg       (i_getimg),
    .i_done_getimg  (i_done_getimg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine: done_getimg high for one cycle, eng_delay cycles after the start cycle.
  always @(negedge clk) begin
    if (o_start_getimg) begin
      m_cnt  <= eng_delay;
      m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (i_reset) begin
      n_ready <= 0;
      n_rsp   <= 0;
      n_sget  <= 0;
      n_sset  <= 0;
      grants.delete();
      sget_cycs.delete();
    end else begin
      if (o_req_ready != '0) begin
        n_ready   <= n_ready + 1;
        issue_cyc <= cyc;
        grants.push_back(o_req_ready);
      end
      if (o_rsp_valid != '0) begin
        n_rsp        <= n_rsp + 1;
        rsp_cyc      <= cyc;
        last_rsp_vec <= o_rsp_valid;
        last_rsp_img <= o_rsp_img;
        last_rsp_err <= o_rsp_err;
      end
      if (o_start_getimg) begin
        n_sget <= n_sget + 1;
        sget_cycs.push_back(cyc);
      end
      if (o_start_setimg) begin
        n_sset        <= n_sset + 1;
        last_sset_img <= o_setimg;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge (monitor updates already applied).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    i_req_valid = '0;
    i_reset     = 1'b1;
    ticks(2);
    i_reset = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int n_exp, input int bound);
    int k = 0;
    while (n_ready < n_exp && k < bound) begin
      tick();
      k++;
    end
    check({tag, "_ready_seen"}, n_ready, n_exp);
  endtask

  task automatic wait_rsp(input string tag, input int n_exp, input int bound);
    int k = 0;
    while (n_rsp < n_exp && k < bound) begin
      tick();
      k++;
    end
    check({tag, "_rsp_seen"}, n_rsp, n_exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, o_req_ready, 0);
    check({tag, "_rspv"}, o_rsp_valid, 0);
    check({tag, "_misc"}, {o_rsp_img, o_rsp_err, o_busy, o_locked,
                           o_start_setimg, o_start_getimg, o_setimg}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: single get with a 50-cycle engine.
    do_reset();
    check_idle_outputs("t1_reset");
    eng_delay   = 50;
    eng_img     = 2'b10;
    i_req_op    = 2'b00;
    i_req_valid = 2'b01;
    wait_ready("t1", 1, 10);
    i_req_valid = 2'b00;
    check("t1_grant", grants[0], 2'b01);
    wait_rsp("t1", 1, 100);
    check("t1_rsp_vec", last_rsp_vec, 2'b01);
    check("t1_rsp_img", last_rsp_img, 2'b10);
    check("t1_rsp_err", last_rsp_err, 0);
    check("t1_rsp_lat", rsp_cyc - issue_cyc, 51);
    ticks(G_CYC - 1);
    check("t1_busy_in_guard", o_busy, 1);
    tick();
    check("t1_busy_after_guard", o_busy, 0);
    check("t1_n_sget", n_sget, 1);
    check("t1_n_rsp", n_rsp, 1);

    // 2: both requesters held for three grants.
    do_reset();
    eng_delay   = 3;
    eng_img     = 2'b01;
    i_req_op    = 2'b00;
    i_req_valid = 2'b11;
    wait_ready("t2", 3, 200);
    i_req_valid = 2'b00;
    check("t2_grant0", grants[0], 2'b01);
    check("t2_grant1", grants[1], 2'b10);
    check("t2_grant2", grants[2], 2'b01);
    check("t2_n_sget", n_sget, 3);
    check("t2_gap01", 32'(sget_cycs[1] - sget_cycs[0] >= int'(G_CYC) + 1), 1);
    check("t2_gap12", 32'(sget_cycs[2] - sget_cycs[1] >= int'(G_CYC) + 1), 1);
    wait_rsp("t2", 3, 100);
    ticks(G_CYC);
    check("t2_idle", o_busy, 0);

    // 3: engine never answers -> timeout.
    do_reset();
    eng_delay   = 0;
    eng_img     = 2'b11;
    i_req_valid = 2'b10;
    wait_ready("t3", 1, 10);
    i_req_valid = 2'b00;
    check("t3_grant", grants[0], 2'b10);
    wait_rsp("t3", 1, 200);
    check("t3_rsp_lat", rsp_cyc - issue_cyc, TO_CYC + 1);
    check("t3_rsp_vec", last_rsp_vec, 2'b10);
    check("t3_rsp_err", last_rsp_err, 1);
    check("t3_rsp_img", last_rsp_img, 2'b00);
    ticks(G_CYC);
    check("t3_idle", o_busy, 0);

    // 4: valid set locks the arbiter.
    do_reset();
    i_req_op    = 2'b10;
    i_req_img   = 4'b1100;
    i_req_valid = 2'b10;
    wait_ready("t4", 1, 10);
    i_req_valid = 2'b00;
    check("t4_grant", grants[0], 2'b10);
    check("t4_n_sset", n_sset, 1);
    check("t4_setimg", last_sset_img, 2'b11);
    check("t4_n_sget", n_sget, 0);
    tick();
    check("t4_locked", o_locked, 1);
    check("t4_busy", o_busy, 1);
    check("t4_setimg_hold", o_setimg, 2'b11);
    i_req_op    = 2'b00;
    i_req_valid = 2'b01;
    stray_done  = 1'b1;
    tick();
    stray_done = 1'b0;
    ticks(60);
    check("t4_no_new_ready", n_ready, 1);
    check("t4_no_rsp", n_rsp, 0);
    check("t4_still_locked", o_locked, 1);
    do_reset();
    check_idle_outputs("t4_reset");

    // 5: set with invalid code -> error response, no lock.
    i_req_op    = 2'b01;
    i_req_img   = 4'b0000;
    i_req_valid = 2'b01;
    wait_ready("t5", 1, 10);
    i_req_valid = 2'b00;
    wait_rsp("t5", 1, 10);
    check("t5_rsp_lat", rsp_cyc - issue_cyc, 1);
    check("t5_rsp_vec", last_rsp_vec, 2'b01);
    check("t5_rsp_err", last_rsp_err, 1);
    check("t5_rsp_img", last_rsp_img, 2'b00);
    check("t5_n_sset", n_sset, 0);
    check("t5_locked", o_locked, 0);
    eng_delay   = 5;
    eng_img     = 2'b01;
    i_req_op    = 2'b00;
    i_req_valid = 2'b10;
    wait_ready("t5b", 2, 50);
    i_req_valid = 2'b00;
    wait_rsp("t5b", 2, 50);
    check("t5b_rsp_vec", last_rsp_vec, 2'b10);
    check("t5b_rsp_img", last_rsp_img, 2'b01);
    check("t5b_rsp_err", last_rsp_err, 0);

    // 6: reset mid-WAIT_GET, then stray done pulses in IDLE.
    do_reset();
    eng_delay   = 40;
    eng_img     = 2'b10;
    i_req_op    = 2'b00;
    i_req_valid = 2'b01;
    wait_ready("t6", 1, 10);
    i_req_valid = 2'b00;
    ticks(10);
    do_reset();
    check_idle_outputs("t6_reset");
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    ticks(50);
    check("t6_no_rsp", n_rsp, 0);
    check("t6_no_grant", n_ready, 0);
    check("t6_idle", o_busy, 0);
    eng_delay   = 5;
    eng_img     = 2'b11;
    i_req_valid = 2'b10;
    wait_ready("t6b", 1, 10);
    i_req_valid = 2'b00;
    wait_rsp("t6b", 1, 50);
    check("t6b_rsp_vec", last_rsp_vec, 2'b10);
    check("t6b_rsp_img", last_rsp_img, 2'b11);
    check("t6b_rsp_err", last_rsp_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
